wimpfi_host_frontend: RTL and testbench



---
 rtl/wimpfi_pkg.sv | 20 ++
 rtl/wimpfi_frame_buf.sv | 31 +++
 rtl/wimpfi_host_frontend.sv | 182 ++++++++++++++++++
 tb/tb_wimpfi_host_frontend.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wimpfi_pkg.sv
// wimpfi_pkg: shared types and default constants for the WimpFi host frontend.
//   state_t            frontend sequencer states
//   WIMPFI_SEND_CHAR   terminal byte that closes and sends a frame
//   WIMPFI_ABORT_CHAR  terminal byte that discards the frame in progress
//   WIMPFI_FTYPE_BASE  ASCII base added to the frame-type switches
package wimpfi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    DRAIN,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] WIMPFI_SEND_CHAR  = 8'h04;
  localparam logic [7:0] WIMPFI_ABORT_CHAR = 8'h1B;
  localparam logic [7:0] WIMPFI_FTYPE_BASE = 8'h30;

endpackage

// File: rtl/wimpfi_frame_buf.sv
// wimpfi_frame_buf: DEPTH x 8 payload store.
//   clk      system clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
// Contents are deliberately not reset; a frame is always written before it is read.
module wimpfi_frame_buf #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wimpfi_host_frontend.sv
// wimpfi_host_frontend: buffers a terminal-typed frame (destination byte plus
// up to DEPTH payload bytes) and hands it to the WimpFi transmitter.
//   clk, rst                  clock, asynchronous active-low reset
//   ftype_sel                 frame-type switches, sampled when a frame closes
//   u_valid, u_data, u_rdy    byte stream from the UART receiver
//   x_busy                    transmitter busy
//   x_start                   one-cycle frame start
//   x_dest, x_ftype, x_len    header fields, held from close until frame done
//   x_valid, x_data, x_rdy    payload byte stream to the transmitter
//   frame_cnt, abort_cnt      wrapping frame statistics
//   full_cnt                  saturating count of frames closed by a full buffer
// DEPTH must be a power of two, at least 2.
//
// state     | meaning
// IDLE      | waiting for a destination byte
// FILL      | collecting payload bytes
// START     | frame closed, waiting for transmitter idle to pulse x_start
// DRAIN     | streaming payload bytes to the transmitter
// WAIT_DONE | all bytes handed over, waiting for the transmitter to finish
module wimpfi_host_frontend
  import wimpfi_pkg::*;
#(
  parameter int         DEPTH      = 256,
  parameter logic [7:0] SEND_CHAR  = WIMPFI_SEND_CHAR,
  parameter logic [7:0] ABORT_CHAR = WIMPFI_ABORT_CHAR,
  parameter int         FTYPE_W    = 2,
  parameter logic [7:0] FTYPE_BASE = WIMPFI_FTYPE_BASE,
  localparam int        LW         = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FTYPE_W-1:0] ftype_sel,
  input  logic               u_valid,
  input  logic [7:0]         u_data,
  output logic               u_rdy,
  input  logic               x_busy,
  output logic               x_start,
  output logic [7:0]         x_dest,
  output logic [7:0]         x_ftype,
  output logic [LW-1:0]      x_len,
  output logic               x_valid,
  output logic [7:0]         x_data,
  input  logic               x_rdy,
  output logic [7:0]         frame_cnt,
  output logic [7:0]         abort_cnt,
  output logic [7:0]         full_cnt
);

  localparam int AW = $clog2(DEPTH);

  state_t        state_q;
  logic [LW-1:0] count_q;
  logic [LW-1:0] rd_ptr_q;
  logic [7:0]    dest_q;
  logic [7:0]    x_dest_q;
  logic [7:0]    x_ftype_q;
  logic [LW-1:0] x_len_q;
  logic [7:0]    frame_cnt_q;
  logic [7:0]    abort_cnt_q;
  logic [7:0]    full_cnt_q;

  logic          u_acc;
  logic          is_send;
  logic          is_abort;
  logic          is_payload;
  logic          buf_we;
  logic [LW-1:0] count_inc;
  logic [7:0]    ftype_byte;
  logic [7:0]    rd_data;

  assign u_rdy      = (state_q == IDLE) || (state_q == FILL);
  assign u_acc      = u_valid && u_rdy;
  assign is_send    = (u_data == SEND_CHAR);
  assign is_abort   = (u_data == ABORT_CHAR);
  assign is_payload = u_acc && !is_send && !is_abort;
  assign buf_we     = is_payload && (state_q == FILL);
  assign count_inc  = count_q + LW'(1);
  assign ftype_byte = FTYPE_BASE + 8'(ftype_sel);

  assign x_start   = (state_q == START) && !x_busy;
  assign x_valid   = (state_q == DRAIN);
  assign x_data    = rd_data;
  assign x_dest    = x_dest_q;
  assign x_ftype   = x_ftype_q;
  assign x_len     = x_len_q;
  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;
  assign full_cnt  = full_cnt_q;

  wimpfi_frame_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .we_i   (buf_we),
    .waddr_i(count_q[AW-1:0]),
    .wdata_i(u_data),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      dest_q      <= '0;
      x_dest_q    <= '0;
      x_ftype_q   <= '0;
      x_len_q     <= '0;
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Control bytes with no frame open are dropped.
          if (is_payload) begin
            dest_q  <= u_data;
            count_q <= '0;
            state_q <= FILL;
          end
        end

        FILL: begin
          if (u_acc) begin
            if (is_send) begin
              if (count_q != '0) begin
                x_dest_q  <= dest_q;
                x_ftype_q <= ftype_byte;
                x_len_q   <= count_q;
                state_q   <= START;
              end else begin
                state_q <= IDLE;
              end
            end else if (is_abort) begin
              count_q     <= '0;
              abort_cnt_q <= abort_cnt_q + 8'd1;
              state_q     <= IDLE;
            end else begin
              count_q <= count_inc;
              if (count_inc == LW'(DEPTH)) begin
                x_dest_q   <= dest_q;
                x_ftype_q  <= ftype_byte;
                x_len_q    <= count_inc;
                full_cnt_q <= (full_cnt_q == 8'hFF) ? full_cnt_q : full_cnt_q + 8'd1;
                state_q    <= START;
              end
            end
          end
        end

        START: begin
          if (!x_busy) begin
            rd_ptr_q <= '0;
            state_q  <= DRAIN;
          end
        end

        DRAIN: begin
          if (x_rdy) begin
            rd_ptr_q <= rd_ptr_q + LW'(1);
            if (rd_ptr_q == x_len_q - LW'(1)) begin
              state_q <= WAIT_DONE;
            end
          end
        end

        WAIT_DONE: begin
          // The transmitter raises x_busy by the cycle after x_start, so by
          // now a low x_busy means the frame is really finished.
          if (!x_busy) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wimpfi_host_frontend.sv
module tb_wimpfi_host_frontend;
  import wimpfi_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   ftype_sel = 2'd0;
  logic         u_valid = 1'b0;
  logic [7:0]   u_data = 8'h00;
  logic         u_rdy;
  logic         x_busy = 1'b0;
  logic         x_start;
  logic [7:0]   x_dest;
  logic [7:0]   x_ftype;
  logic [LW-1:0] x_len;
  logic         x_valid;
  logic [7:0]   x_data;
  logic         x_rdy = 1'b1;
  logic [7:0]   frame_cnt;
  logic [7:0]   abort_cnt;
  logic [7:0]   full_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // transmitter model state
  logic       force_busy = 1'b0;
  logic       rdy_rand = 1'b0;
  logic       pending = 1'b0;
  int         xfer_cnt = 0;
  int         n_start = 0;
  logic       prev_start = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] start_dest[$];

  wimpfi_host_frontend #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .ftype_sel(ftype_sel),
    .u_valid  (u_valid),
    .u_data   (u_data),
    .u_rdy    (u_rdy),
    .x_busy   (x_busy),
    .x_start  (x_start),
    .x_dest   (x_dest),
    .x_ftype  (x_ftype),
    .x_len    (x_len),
    .x_valid  (x_valid),
    .x_data   (x_data),
    .x_rdy    (x_rdy),
    .frame_cnt(frame_cnt),
    .abort_cnt(abort_cnt),
    .full_cnt (full_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter inputs change just after the rising edge.
  always @(posedge clk) begin
    #1;
    x_busy = force_busy || pending;
    x_rdy  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Observe the stream mid-cycle; inputs are stable until the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      pending    = 1'b0;
      xfer_cnt   = 0;
      prev_start = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      chk("rdy_valid_excl", 32'(u_rdy && x_valid), 32'd0);
      if (x_start) begin
        chk("start_single", 32'(prev_start), 32'd0);
        n_start++;
        start_dest.push_back(x_dest);
        pending  = 1'b1;
        xfer_cnt = 0;
      end
      if (prev_hold && x_valid) chk("data_hold", 32'(x_data), 32'(prev_data));
      if (x_valid && x_rdy) begin
        rx_q.push_back(x_data);
        xfer_cnt++;
        if (xfer_cnt == int'(x_len)) pending = 1'b0;
      end
      prev_start = x_start;
      prev_hold  = x_valid && !x_rdy;
      prev_data  = x_data;
    end
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    while (!u_rdy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_rdy", 32'(u_rdy), 32'd1);
    u_valid = 1'b1;
    u_data  = b;
    @(posedge clk); #1;
    u_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (!u_rdy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, 32'(u_rdy), 32'd1);
  endtask

  initial begin
    int base;
    int s0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u_rdy", 32'(u_rdy), 32'd1);
    chk("rst_x_start", 32'(x_start), 32'd0);
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_x_dest", 32'(x_dest), 32'd0);
    chk("rst_x_ftype", 32'(x_ftype), 32'd0);
    chk("rst_x_len", 32'(x_len), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_abort_cnt", 32'(abort_cnt), 32'd0);
    chk("rst_full_cnt", 32'(full_cnt), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // normal frame
    base = rx_q.size();
    ftype_sel = 2'd2;
    send(8'h41); send(8'h48); send(8'h69); send(8'h04);
    #1;
    chk("n_u_rdy_drop", 32'(u_rdy), 32'd0);
    chk("n_x_start", 32'(x_start), 32'd1);
    chk("n_x_valid_late", 32'(x_valid), 32'd0);
    chk("n_x_dest", 32'(x_dest), 32'h41);
    chk("n_x_ftype", 32'(x_ftype), 32'h32);
    chk("n_x_len", 32'(x_len), 32'd2);
    @(posedge clk); #1;
    chk("n_x_valid", 32'(x_valid), 32'd1);
    wait_idle("n_done");
    chk("n_starts", 32'(n_start), 32'd1);
    chk("n_bytes", 32'(rx_q.size() - base), 32'd2);
    chk("n_b0", 32'(rx_q[base]), 32'h48);
    chk("n_b1", 32'(rx_q[base+1]), 32'h69);
    chk("n_frame_cnt", 32'(frame_cnt), 32'd1);

    // empty frame and leading control bytes
    send(8'h04);
    #1;
    chk("e_rdy_after_send", 32'(u_rdy), 32'd1);
    send(8'h41); send(8'h04);
    repeat (3) @(posedge clk);
    #1;
    chk("e_rdy", 32'(u_rdy), 32'd1);
    chk("e_starts", 32'(n_start), 32'd1);
    chk("e_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("e_abort_cnt", 32'(abort_cnt), 32'd0);
    chk("e_full_cnt", 32'(full_cnt), 32'd0);
    chk("e_x_len_held", 32'(x_len), 32'd2);

    // abort then a one-byte frame
    base = rx_q.size();
    send(8'h41); send(8'h61); send(8'h62); send(8'h1B);
    #1;
    chk("a_abort_cnt", 32'(abort_cnt), 32'd1);
    chk("a_rdy", 32'(u_rdy), 32'd1);
    ftype_sel = 2'd1;
    send(8'h42); send(8'h63); send(8'h04);
    wait_idle("a_done");
    chk("a_starts", 32'(n_start), 32'd2);
    chk("a_dest_at_start", 32'(start_dest[n_start-1]), 32'h42);
    chk("a_x_ftype", 32'(x_ftype), 32'h31);
    chk("a_x_len", 32'(x_len), 32'd1);
    chk("a_bytes", 32'(rx_q.size() - base), 32'd1);
    chk("a_b0", 32'(rx_q[base]), 32'h63);
    chk("a_frame_cnt", 32'(frame_cnt), 32'd2);

    // buffer fills: auto-send, then next byte becomes a destination
    base = rx_q.size();
    ftype_sel = 2'd3;
    send(8'h41); send(8'h70); send(8'h71); send(8'h72); send(8'h73);
    #1;
    chk("f_u_rdy", 32'(u_rdy), 32'd0);
    chk("f_x_start", 32'(x_start), 32'd1);
    chk("f_x_len", 32'(x_len), 32'd4);
    chk("f_x_ftype", 32'(x_ftype), 32'h33);
    chk("f_full_cnt", 32'(full_cnt), 32'd1);
    send(8'h74);
    chk("f_frame_cnt1", 32'(frame_cnt), 32'd3);
    chk("f_bytes1", 32'(rx_q.size() - base), 32'd4);
    chk("f_b0", 32'(rx_q[base]), 32'h70);
    chk("f_b1", 32'(rx_q[base+1]), 32'h71);
    chk("f_b2", 32'(rx_q[base+2]), 32'h72);
    chk("f_b3", 32'(rx_q[base+3]), 32'h73);
    chk("f_dest1", 32'(start_dest[n_start-1]), 32'h41);
    send(8'h75); send(8'h04);
    wait_idle("f_done");
    chk("f_dest2", 32'(start_dest[n_start-1]), 32'h74);
    chk("f_x_len2", 32'(x_len), 32'd1);
    chk("f_b4", 32'(rx_q[base+4]), 32'h75);
    chk("f_frame_cnt2", 32'(frame_cnt), 32'd4);
    chk("f_full_cnt2", 32'(full_cnt), 32'd1);

    // busy hold at START, random backpressure while draining
    base = rx_q.size();
    s0 = n_start;
    force_busy = 1'b1;
    send(8'h50); send(8'h31); send(8'h32); send(8'h33); send(8'h04);
    repeat (10) @(posedge clk);
    #1;
    chk("b_no_start", 32'(n_start), 32'(s0));
    chk("b_x_valid", 32'(x_valid), 32'd0);
    chk("b_u_rdy", 32'(u_rdy), 32'd0);
    force_busy = 1'b0;
    rdy_rand = 1'b1;
    wait_idle("b_done");
    rdy_rand = 1'b0;
    chk("b_starts", 32'(n_start), 32'(s0 + 1));
    chk("b_dest", 32'(start_dest[n_start-1]), 32'h50);
    chk("b_bytes", 32'(rx_q.size() - base), 32'd3);
    chk("b_b0", 32'(rx_q[base]), 32'h31);
    chk("b_b1", 32'(rx_q[base+1]), 32'h32);
    chk("b_b2", 32'(rx_q[base+2]), 32'h33);
    chk("b_frame_cnt", 32'(frame_cnt), 32'd5);

    // reset in the middle of DRAIN
    base = rx_q.size();
    send(8'h60); send(8'h78); send(8'h79); send(8'h7A); send(8'h04);
    begin
      int t = 0;
      while (!x_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      chk("r_drain_reached", 32'(x_valid), 32'd1);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("r_x_valid", 32'(x_valid), 32'd0);
    chk("r_u_rdy", 32'(u_rdy), 32'd1);
    chk("r_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("r_abort_cnt", 32'(abort_cnt), 32'd0);
    chk("r_full_cnt", 32'(full_cnt), 32'd0);
    chk("r_x_dest", 32'(x_dest), 32'd0);
    chk("r_x_len", 32'(x_len), 32'd0);
    chk("r_bytes", 32'(rx_q.size() - base), 32'd1);
    chk("r_b0", 32'(rx_q[base]), 32'h78);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    base = rx_q.size();
    ftype_sel = 2'd0;
    send(8'h61); send(8'h6B); send(8'h6C); send(8'h04);
    wait_idle("r2_done");
    chk("r2_dest", 32'(start_dest[n_start-1]), 32'h61);
    chk("r2_x_ftype", 32'(x_ftype), 32'h30);
    chk("r2_bytes", 32'(rx_q.size() - base), 32'd2);
    chk("r2_b0", 32'(rx_q[base]), 32'h6B);
    chk("r2_b1", 32'(rx_q[base+1]), 32'h6C);
    chk("r2_frame_cnt", 32'(frame_cnt), 32'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
